// File: rtl/burst_detector.sv
// burst_detector: synchronises the raw modulated delay-line input into the
// PLL clock domain and turns each carrier burst into single-cycle start/end
// strobes plus an edge count. Bursts too short to confirm are flagged as glitches.
module burst_detector #(
    parameter int MIN_EDGES  = 4,
    parameter int GAP_CYCLES = 12,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_sig,
    output logic                 pulse_start,
    output logic                 pulse_end,
    output logic [CNT_WIDTH-1:0] pulse_len,
    output logic                 glitch,
    output logic                 carrier_active
);

    localparam int GAP_WIDTH = $clog2(GAP_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMING = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MIN_CNT  = CNT_WIDTH'(MIN_EDGES);
    localparam logic [GAP_WIDTH-1:0] GAP_LAST = GAP_WIDTH'(GAP_CYCLES - 1);
    localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1);

    logic s1, s2, s3;
    logic carrier_edge;

    logic [1:0]           state, state_d;
    logic [CNT_WIDTH-1:0] edge_cnt, edge_cnt_d, edge_cnt_inc;
    logic [GAP_WIDTH-1:0] gap_cnt, gap_cnt_d;
    logic [CNT_WIDTH-1:0] pulse_len_d;
    logic                 start_d, end_d, glitch_d;

    // Three-flop chain: s1 absorbs metastability, s2/s3 give a clean edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign carrier_edge = s2 & ~s3;

    // Edge counter holds at its maximum rather than wrapping on very long bursts.
    assign edge_cnt_inc = (edge_cnt == CNT_MAX) ? edge_cnt : edge_cnt + CNT_ONE;

    // Burst FSM next-state logic; a carrier edge always beats the gap limit.
    always_comb begin
        state_d     = state;
        edge_cnt_d  = edge_cnt;
        gap_cnt_d   = gap_cnt;
        pulse_len_d = pulse_len;
        start_d     = 1'b0;
        end_d       = 1'b0;
        glitch_d    = 1'b0;
        case (state)
            IDLE: begin
                if (carrier_edge) begin
                    edge_cnt_d = CNT_ONE;
                    gap_cnt_d  = '0;
                    if (MIN_EDGES <= 1) begin
                        state_d = ACTIVE;
                        start_d = 1'b1;
                    end else begin
                        state_d = ARMING;
                    end
                end
            end
            ARMING: begin
                if (carrier_edge) begin
                    edge_cnt_d = edge_cnt_inc;
                    gap_cnt_d  = '0;
                    if (edge_cnt_inc == MIN_CNT) begin
                        state_d = ACTIVE;
                        start_d = 1'b1;
                    end
                end else if (gap_cnt == GAP_LAST) begin
                    state_d    = IDLE;
                    glitch_d   = 1'b1;
                    edge_cnt_d = '0;
                    gap_cnt_d  = '0;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_ONE;
                end
            end
            ACTIVE: begin
                if (carrier_edge) begin
                    edge_cnt_d = edge_cnt_inc;
                    gap_cnt_d  = '0;
                end else if (gap_cnt == GAP_LAST) begin
                    state_d     = IDLE;
                    end_d       = 1'b1;
                    pulse_len_d = edge_cnt;
                    edge_cnt_d  = '0;
                    gap_cnt_d   = '0;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_ONE;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
                gap_cnt_d  = '0;
            end
        endcase
    end

    // State, counters and registered strobes; reset drops everything mid-burst silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            edge_cnt    <= '0;
            gap_cnt     <= '0;
            pulse_len   <= '0;
            pulse_start <= 1'b0;
            pulse_end   <= 1'b0;
            glitch      <= 1'b0;
        end else begin
            state       <= state_d;
            edge_cnt    <= edge_cnt_d;
            gap_cnt     <= gap_cnt_d;
            pulse_len   <= pulse_len_d;
            pulse_start <= start_d;
            pulse_end   <= end_d;
            glitch      <= glitch_d;
        end
    end

    assign carrier_active = (state == ACTIVE);

endmodule

// File: tb/tb_burst_detector.sv
// tb_burst_detector: directed checks of burst confirmation, termination,
// glitch rejection, saturation, back-to-back bursts and mid-burst reset.
`timescale 1ns/1ps
module tb_burst_detector;

    localparam int CNT_WIDTH = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_sig = 1'b0;
    logic                 pulse_start;
    logic                 pulse_end;
    logic [CNT_WIDTH-1:0] pulse_len;
    logic                 glitch;
    logic                 carrier_active;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int active_cycles = 0;
    int both_cycles = 0;
    int start_q[$];
    int end_q[$];
    int glitch_q[$];
    int len_q[$];
    int edge_k[$];

    burst_detector #(
        .MIN_EDGES (4),
        .GAP_CYCLES(12),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_sig        (in_sig),
        .pulse_start   (pulse_start),
        .pulse_end     (pulse_end),
        .pulse_len     (pulse_len),
        .glitch        (glitch),
        .carrier_active(carrier_active)
    );

    // 81 MHz clock.
    always #6.173 clk = ~clk;

    // Counts rising clock edges so strobe times can be compared against sample times.
    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe with the cycle it was seen in, sampled mid-cycle.
    always @(negedge clk) begin
        if (pulse_start) start_q.push_back(cyc);
        if (glitch) glitch_q.push_back(cyc);
        if (pulse_end) begin
            end_q.push_back(cyc);
            len_q.push_back(int'(pulse_len));
        end
        if (carrier_active) active_cycles++;
        if (pulse_start && pulse_end) both_cycles++;
    end

    // Drives n carrier cycles from a falling clock edge; logs the clock that samples each rise.
    task automatic applyStimulus(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            in_sig = 1'b1;
            edge_k.push_back(cyc + 1);
            repeat (hi) @(negedge clk);
            in_sig = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic quiet(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Directed test sequence.
    initial begin
        int s0, e0, g0, a0, k_post;

        rst_n  = 1'b0;
        in_sig = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_pulse_start", 32'(pulse_start), 0);
        checkOutput("rst_pulse_end", 32'(pulse_end), 0);
        checkOutput("rst_glitch", 32'(glitch), 0);
        checkOutput("rst_carrier_active", 32'(carrier_active), 0);
        checkOutput("rst_pulse_len", 32'(pulse_len), 0);
        rst_n = 1'b1;
        quiet(5);

        $display("[TB] nominal pulse");
        s0 = start_q.size(); e0 = end_q.size(); g0 = glitch_q.size();
        edge_k.delete();
        applyStimulus(12, 3, 3);
        quiet(81);
        checkOutput("nom_starts", 32'(start_q.size() - s0), 1);
        checkOutput("nom_start_time", 32'(qat(start_q, s0)), 32'(edge_k[3] + 2));
        checkOutput("nom_ends", 32'(end_q.size() - e0), 1);
        checkOutput("nom_end_time", 32'(qat(end_q, e0)), 32'(edge_k[11] + 14));
        checkOutput("nom_len", 32'(qat(len_q, e0)), 12);
        checkOutput("nom_glitches", 32'(glitch_q.size() - g0), 0);
        checkOutput("nom_len_held", 32'(pulse_len), 12);

        $display("[TB] short glitch");
        s0 = start_q.size(); e0 = end_q.size(); g0 = glitch_q.size(); a0 = active_cycles;
        edge_k.delete();
        applyStimulus(3, 3, 3);
        quiet(40);
        checkOutput("gl_glitches", 32'(glitch_q.size() - g0), 1);
        checkOutput("gl_time", 32'(qat(glitch_q, g0)), 32'(edge_k[2] + 14));
        checkOutput("gl_starts", 32'(start_q.size() - s0), 0);
        checkOutput("gl_ends", 32'(end_q.size() - e0), 0);
        checkOutput("gl_active", 32'(active_cycles - a0), 0);
        checkOutput("gl_len_held", 32'(pulse_len), 12);

        $display("[TB] boundary gap 11");
        s0 = start_q.size(); e0 = end_q.size(); g0 = glitch_q.size();
        edge_k.delete();
        applyStimulus(10, 3, 9);
        quiet(40);
        checkOutput("b11_starts", 32'(start_q.size() - s0), 1);
        checkOutput("b11_ends", 32'(end_q.size() - e0), 1);
        checkOutput("b11_len", 32'(qat(len_q, e0)), 10);
        checkOutput("b11_end_time", 32'(qat(end_q, e0)), 32'(edge_k[9] + 14));
        checkOutput("b11_glitches", 32'(glitch_q.size() - g0), 0);

        $display("[TB] boundary gap 12");
        s0 = start_q.size(); e0 = end_q.size(); g0 = glitch_q.size();
        edge_k.delete();
        applyStimulus(10, 3, 10);
        quiet(40);
        checkOutput("b12_glitches", 32'(glitch_q.size() - g0), 10);
        checkOutput("b12_last_glitch", 32'(qat(glitch_q, g0 + 9)), 32'(edge_k[9] + 14));
        checkOutput("b12_starts", 32'(start_q.size() - s0), 0);
        checkOutput("b12_ends", 32'(end_q.size() - e0), 0);

        $display("[TB] saturation");
        s0 = start_q.size(); e0 = end_q.size();
        edge_k.delete();
        applyStimulus(100, 3, 3);
        quiet(40);
        checkOutput("sat_starts", 32'(start_q.size() - s0), 1);
        checkOutput("sat_ends", 32'(end_q.size() - e0), 1);
        checkOutput("sat_len", 32'(qat(len_q, e0)), 63);

        $display("[TB] back-to-back 1,0,1");
        s0 = start_q.size(); e0 = end_q.size();
        edge_k.delete();
        applyStimulus(12, 3, 3);
        quiet(90);
        quiet(162);
        applyStimulus(12, 3, 3);
        quiet(90);
        checkOutput("b2b_starts", 32'(start_q.size() - s0), 2);
        checkOutput("b2b_ends", 32'(end_q.size() - e0), 2);
        checkOutput("b2b_len0", 32'(qat(len_q, e0)), 12);
        checkOutput("b2b_len1", 32'(qat(len_q, e0 + 1)), 12);
        checkOutput("b2b_spacing", 32'(qat(start_q, s0 + 1) - qat(start_q, s0)), 324);

        $display("[TB] reset mid-burst");
        s0 = start_q.size(); e0 = end_q.size(); g0 = glitch_q.size();
        edge_k.delete();
        k_post = 0;
        applyStimulus(6, 3, 3);
        for (int t = 0; t < 36; t++) begin
            in_sig = ((t % 6) < 3);
            rst_n  = (t >= 10);
            if (t == 30) k_post = cyc + 1;
            #1;
            if (t < 10) begin
                checkOutput("rst_mid_outputs",
                    {26'd0, pulse_start, pulse_end, glitch, carrier_active, 2'd0} | 32'(pulse_len), 0);
            end
            @(negedge clk);
        end
        in_sig = 1'b0;
        quiet(40);
        checkOutput("rst_starts", 32'(start_q.size() - s0), 2);
        checkOutput("rst_new_start_time", 32'(qat(start_q, s0 + 1)), 32'(k_post + 2));
        checkOutput("rst_ends", 32'(end_q.size() - e0), 1);
        checkOutput("rst_len", 32'(qat(len_q, e0)), 4);
        checkOutput("rst_glitches", 32'(glitch_q.size() - g0), 0);

        checkOutput("start_end_overlap", 32'(both_cycles), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_detector.md
# burst_detector

Front-end stage of the delay line that sits directly upstream of the delay storage. It takes the raw, asynchronous modulated input (13.5 MHz carrier bursts of about 0.9 µs per EDSAC '1' pulse) and synchronises it into the 81 MHz PLL clock domain. It reduces each carrier burst to clean single-cycle start/end strobes and an edge count that the storage stage consumes. Short carrier glitches are rejected and flagged.

## Interface
- `MIN_EDGES`, 4: carrier rising edges needed to declare a burst.
- `GAP_CYCLES`, 12: consecutive edge-free clocks that end a burst (2 carrier periods at 81 MHz).
- `CNT_WIDTH`, 6: width of the edge counter and `pulse_len`.
- `clk`  in  1  81 MHz PLL clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_sig`  in  1  raw modulated input, asynchronous to `clk`.
- `pulse_start`  out  1  one-cycle strobe when a burst is confirmed.
- `pulse_end`  out  1  one-cycle strobe when a confirmed burst terminates.
- `pulse_len`  out  CNT_WIDTH  edge count of the burst; valid while `pulse_end`=1, held until the next `pulse_end`.
- `glitch`  out  1  one-cycle strobe when an unconfirmed burst is abandoned.
- `carrier_active`  out  1  high while the FSM is in ACTIVE.

## Operation
- Three-flop chain on `in_sig`: s1, s2, s3. `edge` = s2 & ~s3 (combinational). Only s1 may go metastable.
- Registers:
  - `edge_cnt` (CNT_WIDTH): saturates at 2^CNT_WIDTH−1, no wrap.
  - `gap_cnt`: ceil(log2(GAP_CYCLES+1)) bits.
  - `state`.
- FSM states and transitions:
  - IDLE:
    - On `edge` → ARMING, `edge_cnt`=1, `gap_cnt`=0.
    - If MIN_EDGES=1, go straight to ACTIVE and strobe `pulse_start` instead.
  - ARMING:
    - On `edge`: `edge_cnt`++, `gap_cnt`=0. If the new count equals MIN_EDGES → ACTIVE, `pulse_start`=1.
    - With no `edge`: `gap_cnt`++. If `gap_cnt`=GAP_CYCLES−1 → IDLE, `glitch`=1, `edge_cnt`=0.
  - ACTIVE:
    - On `edge`: `edge_cnt`++ (saturating), `gap_cnt`=0.
    - With no `edge`: `gap_cnt`++. If `gap_cnt`=GAP_CYCLES−1 → IDLE, `pulse_end`=1, `pulse_len`=`edge_cnt`, `edge_cnt`=0.
- Simultaneous events:
  - An `edge` in the cycle the gap limit would be reached always wins. The gap counter clears and the state is kept.
  - An `edge` in IDLE on the cycle right after termination starts a new ARMING.
  - `pulse_end` and `pulse_start` never assert in the same cycle.
- All strobes are registered outputs and high for exactly one clock.
- Reset values:
  - s1–s3 = 0, state = IDLE, counters = 0.
  - `pulse_start`, `pulse_end`, `glitch`, `carrier_active` = 0.
  - `pulse_len` = 0.
- Reset mid-burst: everything clears immediately and no strobes are emitted. After release, carrier edges are treated as a new burst and go through ARMING again.

## Timing
- Input sampled high at clock edge k (s1 = 1):
  - `edge` is high between edges k+1 and k+2.
  - The FSM registers it at k+2.
  - The resulting strobe is high from k+2 to k+3.
  - Input-to-strobe latency is 2 clocks.
- `pulse_start` fires 2 clocks after the MIN_EDGES-th rising edge is first sampled.
- `pulse_end` is high in the cycle following the GAP_CYCLES-th consecutive edge-free clock after the last edge was registered.
  - Last edge registered at clock m → `pulse_end` high from m+GAP_CYCLES to m+GAP_CYCLES+1.
  - `carrier_active` falls on the same clock edge.
- `carrier_active` rises on the same clock edge as `pulse_start`.
- Nominal 13.5 MHz carrier at 81 MHz gives 6 clocks per carrier period: 5 edge-free clocks between edges, well below GAP_CYCLES.

## Test plan
- Nominal pulse: 12 carrier cycles (37 ns high / 37 ns low), then 1 µs quiet → one `pulse_start` 2 clocks after the 4th edge, one `pulse_end` with `pulse_len`=12 exactly 12 clocks after the last edge registers, `glitch` never set.
- Glitch: 3 carrier cycles, then quiet → `glitch` once, 12 clocks after the 3rd edge registers; no `pulse_start`, no `pulse_end`, `carrier_active` stays 0.
- Boundary carrier: edges every 12 clocks (11 edge-free clocks) for 10 edges → a single burst with `pulse_len`=10. Edges every 13 clocks (12 edge-free clocks) → burst terminates after every edge: 10 `glitch` strobes, no `pulse_start`.
- Saturation: 100 continuous carrier cycles → one `pulse_start`, one `pulse_end` with `pulse_len`=63.
- Back-to-back: EDSAC pattern 1,0,1 (0.9 µs burst / 1.1 µs gap per bit slot) → exactly two start/end pairs, both `pulse_len`=12, starts spaced ≈4.0 µs (324 ±1 clocks).
- Reset: assert `rst_n`=0 after the 6th edge of a burst, release 10 clocks later while the carrier continues for 6 more cycles → all outputs 0 during reset, no `pulse_end` for the first burst; a new burst is confirmed after 4 post-reset edges, and `pulse_len`≤6 at its end.
